// File: rtl/sha_msg_schedule.sv
// SHA-2 message schedule: expands one 16-word block into ROUNDS words with a 16-entry sliding window.
// Optional SHA_SCHED_BACK2BACK_EN loads the next block on the final beat, so no bubble separates blocks.
module sha_msg_schedule #(
  parameter int DATA_WIDTH = 32,
  parameter int ROUNDS     = 64,
  parameter int IDX_W      = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      block_valid,
  output logic                      block_ready,
  input  logic [16*DATA_WIDTH-1:0]  block_data,
  output logic                      w_valid,
  input  logic                      w_ready,
  output logic [DATA_WIDTH-1:0]     w_data,
  output logic [IDX_W-1:0]          w_index,
  output logic                      w_last,
  output logic                      state_dbg
);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("sha_msg_schedule: DATA_WIDTH must be 32 or 64");
  end
  if (ROUNDS < 16 || ROUNDS > 128) begin : g_bad_rounds
    $error("sha_msg_schedule: ROUNDS must be in 16..128");
  end
  if ((1 << IDX_W) < ROUNDS) begin : g_bad_idx
    $error("sha_msg_schedule: IDX_W too narrow for ROUNDS");
  end

  localparam int S0_A = (DATA_WIDTH == 64) ? 1  : 7;
  localparam int S0_B = (DATA_WIDTH == 64) ? 8  : 18;
  localparam int S0_S = (DATA_WIDTH == 64) ? 7  : 3;
  localparam int S1_A = (DATA_WIDTH == 64) ? 19 : 17;
  localparam int S1_B = (DATA_WIDTH == 64) ? 61 : 19;
  localparam int S1_S = (DATA_WIDTH == 64) ? 6  : 10;
  localparam logic [IDX_W-1:0] LAST_T = IDX_W'(ROUNDS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state;
  logic [IDX_W-1:0]      t;
  logic [DATA_WIDTH-1:0] win [16];
  logic [DATA_WIDTH-1:0] next_w;
  logic                  at_last, beat, accept;

  function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x, input int n);
    return (x >> n) | (x << (DATA_WIDTH - n));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sigma0(input logic [DATA_WIDTH-1:0] x);
    return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_S);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sigma1(input logic [DATA_WIDTH-1:0] x);
    return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_S);
  endfunction

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never drops without a transfer, and data/index/last hold while ready is low.
  assign at_last = (t == LAST_T);
  assign beat    = (state == RUN) && w_ready;
  assign accept  = block_valid && block_ready;

`ifdef SHA_SCHED_BACK2BACK_EN
  assign block_ready = (state == IDLE) || ((state == RUN) && at_last && w_ready);
`else
  assign block_ready = (state == IDLE);
`endif

  assign w_valid   = (state == RUN);
  assign w_data    = win[0];
  assign w_index   = t;
  assign w_last    = (state == RUN) && at_last;
  assign state_dbg = (state == RUN);

  // Window indices are shifted by t: win[14]=W(t+14) plays W(t+16-2), win[1] plays W(t+16-15).
  always_comb begin
    next_w = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t     <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      if (beat && !at_last) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= next_w;
        t       <= t + 1'b1;
      end
      if (beat && at_last) state <= IDLE;
      // A load on the final beat overrides the return to IDLE.
      if (accept) begin
        for (int i = 0; i < 16; i++) win[i] <= block_data[(16-i)*DATA_WIDTH-1 -: DATA_WIDTH];
        t     <= '0;
        state <= RUN;
      end
    end
  end

endmodule

// File: doc/sha_msg_schedule.md
Name: sha_msg_schedule

Overview:
Sequential SHA-2 message-schedule generator that expands one 16-word block into ROUNDS schedule words W0..W(ROUNDS-1), one word per accepted beat. It applies small-sigma0 and small-sigma1 internally, with rotation constants selected by DATA_WIDTH. It sits between the padder and the compression round core. A 16-word sliding window replaces per-round combinational sigma instances.

Parameters:
DATA_WIDTH, 32, word width. 32 selects SHA-256 constants; 64 selects SHA-512 constants. Any other value is an elaboration error.
ROUNDS, 64, number of schedule words emitted per block. Legal range 16..128; 64 for SHA-256, 80 for SHA-512.
IDX_W, 7, width of w_index. Must satisfy 2^IDX_W >= ROUNDS.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
block_valid  in  1  a 16-word block is presented.
block_ready  out  1  block accepted on (block_valid & block_ready).
block_data  in  16*DATA_WIDTH  message block; W0 = bits [16*DW-1 -: DW], W15 = bits [DW-1:0].
w_valid  out  1  w_data holds a valid schedule word.
w_ready  in  1  consumer accepts a word on (w_valid & w_ready).
w_data  out  DATA_WIDTH  schedule word Wt.
w_index  out  IDX_W  value of t for w_data.
w_last  out  1  high with the word at t = ROUNDS-1.

Behaviour:
- Sigma functions:
  - DW=32: s0 = ROTR7 ^ ROTR18 ^ SHR3; s1 = ROTR17 ^ ROTR19 ^ SHR10.
  - DW=64: s0 = ROTR1 ^ ROTR8 ^ SHR7; s1 = ROTR19 ^ ROTR61 ^ SHR6.
- State: 16-entry window win[0..15] holds W(t)..W(t+15); counter t. FSM states are IDLE and RUN.
- Reset (asynchronous, any time including mid-block):
  - Outputs: block_ready=1, w_valid=0, w_last=0, w_index=0, w_data=0.
  - State goes to IDLE; window cleared. The partial block is discarded and never resumed.
- IDLE:
  - block_ready=1, w_valid=0.
  - On block accept: win <= block words, t <= 0, go to RUN.
- RUN:
  - block_ready=0 (see Optional Feature), w_valid=1, w_data=win[0], w_index=t, w_last=(t==ROUNDS-1).
  - Latency: block accepted at edge N; W0 is valid in the cycle after edge N.
- Beat (w_valid & w_ready, t < ROUNDS-1):
  - win[i] <= win[i+1] for i=0..14.
  - win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0], computed modulo 2^DATA_WIDTH (carries dropped).
  - t <= t+1.
- Beat at t = ROUNDS-1: go to IDLE; w_valid drops on the next cycle.
- Back-pressure: with w_ready=0, w_data, w_index, w_last and the window hold stable indefinitely. w_valid never deasserts in RUN without a beat.
- Throughput: one word per cycle while w_ready=1. Without the optional feature, there is one idle cycle between blocks (ROUNDS+1 cycles per block).
- block_valid while block_ready=0 is ignored. The producer must hold it.

Optional Feature:
SHA_SCHED_BACK2BACK_EN
- Defined:
  - block_ready = IDLE | (RUN & w_last & w_ready).
  - If the last beat and a block accept occur on the same edge, the new block loads, t <= 0 and the FSM stays in RUN.
  - W0 of the next block follows W(ROUNDS-1) with no bubble (ROUNDS cycles per block).
- Undefined: block_ready is high only in IDLE, and the one-cycle gap applies.

Test Plan:
- DW=32, "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB, w_last only at index 63, block_ready high again after 65 cycles.
- DW=64, ROUNDS=80, "abc" (W0=0x6162638000000000, W15=0x18) -> W16=0x6162638000000000, W17=0x00030000000000C0, w_last at index 79.
- Back-pressure: w_ready low for 5 cycles at t=20 -> w_data, w_index=20 and w_last stable; the sequence resumes with W21 and the full stream is unchanged versus the no-stall run.
- Reset asserted at t=30 for 2 cycles -> w_valid=0 and block_ready=1 asynchronously; a new block then starts at w_index=0 with correct W0.
- Two blocks offered back-to-back -> macro undefined: one w_valid=0 cycle between W63 and the next W0; macro defined: zero gap, and the second block's W0 follows W63 directly.
- block_valid toggled during RUN -> no accept, stream unaffected.
